muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl_pkg.sv | 31 +++
 rtl/muldiv_ctrl_if.sv | 22 ++
 rtl/muldiv_ctrl_md_alu.sv | 53 +++++
 rtl/muldiv_ctrl.sv | 106 ++++++++++
 tb/tb_muldiv_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the MIPS multiply/divide sequencer: op codes, FSM states
// and op classification helpers.
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_MADD  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_long_op(input logic [2:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the MD controller.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, md_use_d,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, a, b, md_use_d,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl_md_alu.sv
// Combinational 64-bit {hi,lo} result generator for the multiply/divide ops.
module md_alu
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    always_comb begin
        prod_s      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u      = {32'd0, a} * {32'd0, b};
        div_by_zero = (b == 32'd0);
        quo_s       = 32'd0;
        rem_s       = 32'd0;
        quo_u       = 32'd0;
        rem_u       = 32'd0;

        // The most-negative / -1 case overflows a 32-bit signed divide; pin it explicitly.
        if (!div_by_zero) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quo_s = 32'h8000_0000;
                rem_s = 32'd0;
            end else begin
                quo_s = $unsigned($signed(a) / $signed(b));
                rem_s = $unsigned($signed(a) % $signed(b));
            end
            quo_u = a / b;
            rem_u = a % b;
        end

        case (op)
            MD_MULT:  result = $unsigned(prod_s);
            MD_MULTU: result = prod_u;
            MD_MADD:  result = {hi, lo} + $unsigned(prod_s);
            MD_DIV:   result = {rem_s, quo_s};
            MD_DIVU:  result = {rem_u, quo_u};
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MD sequencer: busy counter, pending operands, HI/LO and the D-stage stall.
module muldiv_ctrl
    import md_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_ctrl_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t   state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [2:0]  pend_op_reg, pend_op_next;
    logic [31:0] pend_a_reg, pend_a_next;
    logic [31:0] pend_b_reg, pend_b_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    logic [63:0] alu_result;
    logic        alu_div_by_zero;
    logic        commit;

    // Operands come from the pending registers; hi/lo are frozen while busy, so MADD sees commit-time values.
    md_alu u_alu (
        .op          (pend_op_reg),
        .a           (pend_a_reg),
        .b           (pend_b_reg),
        .hi          (hi_reg),
        .lo          (lo_reg),
        .result      (alu_result),
        .div_by_zero (alu_div_by_zero)
    );

    assign commit = (state_reg == BUSY) && (count_reg == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            pend_op_reg <= MD_NONE;
            pend_a_reg  <= '0;
            pend_b_reg  <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            pend_op_reg <= pend_op_next;
            pend_a_reg  <= pend_a_next;
            pend_b_reg  <= pend_b_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        pend_op_next = pend_op_reg;
        pend_a_next  = pend_a_reg;
        pend_b_next  = pend_b_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;

        case (state_reg)
            IDLE: begin
                if (md.start) begin
                    if (is_long_op(md.op)) begin
                        pend_op_next = md.op;
                        pend_a_next  = md.a;
                        pend_b_next  = md.b;
                        count_next   = is_div_op(md.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_next   = BUSY;
                    end else if (md.op == MD_MTHI) begin
                        hi_next = md.a;
                    end else if (md.op == MD_MTLO) begin
                        lo_next = md.a;
                    end
                end
            end
            BUSY: begin
                count_next = count_reg - CNT_W'(1);
                if (commit) begin
                    count_next = '0;
                    state_next = IDLE;
                    // Divide by zero burns the full latency but leaves HI/LO untouched.
                    if (!(is_div_op(pend_op_reg) && alu_div_by_zero)) begin
                        {hi_next, lo_next} = alu_result;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign md.busy     = (state_reg == BUSY);
    assign md.stall_md = md.md_use_d & ((state_reg == BUSY) | (md.start & is_long_op(md.op)));
    assign md.hi       = hi_reg;
    assign md.lo       = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus random checks of muldiv_ctrl against an arithmetic HI/LO model.
module tb_muldiv_ctrl;
    import md_defs::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    logic [31:0] mhi;
    logic [31:0] mlo;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected HI/LO after an op, straight from the arithmetic definitions.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
        longint          ps;
        longint unsigned pu;
        longint          q;
        longint          r;
        logic [63:0]     acc;
        ps = longint'($signed(aa)) * longint'($signed(bb));
        pu = longint'(aa) * longint'(bb);
        case (o)
            MD_MULT:  {mhi, mlo} = ps;
            MD_MULTU: {mhi, mlo} = pu;
            MD_MADD: begin
                acc = {mhi, mlo};
                acc = acc + ps;
                {mhi, mlo} = acc;
            end
            MD_DIV: if (bb != 0) begin
                q = longint'($signed(aa)) / longint'($signed(bb));
                r = longint'($signed(aa)) % longint'($signed(bb));
                mlo = q[31:0];
                mhi = r[31:0];
            end
            MD_DIVU: if (bb != 0) begin
                mlo = aa / bb;
                mhi = aa % bb;
            end
            MD_MTHI: mhi = aa;
            MD_MTLO: mlo = aa;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic use_d);
        int n;
        n = (o == MD_MULT || o == MD_MULTU || o == MD_MADD) ? MULT_N :
            (o == MD_DIV || o == MD_DIVU) ? DIV_N : 0;
        bus.start    = 1'b1;
        bus.op       = o;
        bus.a        = aa;
        bus.b        = bb;
        bus.md_use_d = use_d;
        #1;
        check("start_busy", {31'd0, bus.busy}, 32'd0);
        check("start_stall", {31'd0, bus.stall_md}, {31'd0, use_d && (n > 0)});
        step();
        bus.start = 1'b0;
        bus.op    = MD_NONE;
        bus.a     = $urandom;
        bus.b     = $urandom;
        for (int i = 0; i < n; i++) begin
            check("busy_hi", {31'd0, bus.busy}, 32'd1);
            check("busy_stall", {31'd0, bus.stall_md}, {31'd0, use_d});
            check("busy_hold_hi", bus.hi, mhi);
            step();
        end
        model_apply(o, aa, bb);
        check("done_busy", {31'd0, bus.busy}, 32'd0);
        check("done_stall", {31'd0, bus.stall_md}, 32'd0);
        check("hi", bus.hi, mhi);
        check("lo", bus.lo, mlo);
        $display("[TB] op=%0d a=%h b=%h use_d=%0d -> hi=%h lo=%h (model hi=%h lo=%h)",
                 o, aa, bb, use_d, bus.hi, bus.lo, mhi, mlo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        tests        = 0;
        failed       = 0;
        mhi          = 32'd0;
        mlo          = 32'd0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op       = MD_NONE;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.md_use_d = 1'b1;
        step();
        step();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_stall", {31'd0, bus.stall_md}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        // Reset must win over a simultaneous start.
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.a     = 32'hDEAD_BEEF;
        step();
        bus.start = 1'b0;
        check("rst_vs_start", bus.hi, 32'd0);
        reset = 1'b0;
        bus.md_use_d = 1'b0;

        do_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(MD_DIVU,  32'd7, 32'd2, 1'b0);
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(MD_MTHI,  32'h11, 32'd0, 1'b0);
        do_op(MD_MTLO,  32'h22, 32'd0, 1'b0);
        do_op(MD_DIV,   32'd5, 32'd0, 1'b0);
        do_op(MD_MTHI,  32'h1234, 32'd0, 1'b1);
        do_op(MD_MTLO,  32'h5678, 32'd0, 1'b1);
        do_op(MD_MTHI,  32'd0, 32'd0, 1'b0);
        do_op(MD_MTLO,  32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(MD_MADD,  32'd1, 32'd1, 1'b0);
        do_op(MD_MULT,  32'd6, 32'd7, 1'b1);
        do_op(MD_MULT,  32'd6, 32'd7, 1'b0);
        do_op(MD_NONE,  32'h9999, 32'h1, 1'b1);

        // Abort a divide in its 4th busy cycle.
        bus.start = 1'b1;
        bus.op    = MD_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        step();
        bus.start = 1'b0;
        bus.op    = MD_NONE;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        do_op(MD_MULTU, 32'd3, 32'd4, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
